// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front-end blocks.
package cpu_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    localparam int unsigned PC_STEP_DEFAULT = 4;

    // IDLE: nothing outstanding; FETCH: live request awaiting ack;
    // DROP: request outstanding whose returned data must be thrown away.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_buf.sv
// Two-entry {pc, inst} FIFO between the fetch engine and the IF/ID register.
// Entry 0 is always the head, so the presented outputs come straight from flops.
module if_fetch_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_inst,
    output logic [31:0] head_pc,
    output logic [31:0] head_inst,
    output logic [1:0]  count
);

    logic [1:0] count_q, count_d;
    addr_t      e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
    word_t      e0_inst_q, e0_inst_d, e1_inst_q, e1_inst_d;
    logic       do_pop;

    assign do_pop    = pop && (count_q != 2'd0);
    assign head_pc   = e0_pc_q;
    assign head_inst = e0_inst_q;
    assign count     = count_q;

    // Next-state: flush empties the FIFO and wins over a simultaneous push.
    always_comb begin
        count_d   = count_q;
        e0_pc_d   = e0_pc_q;
        e0_inst_d = e0_inst_q;
        e1_pc_d   = e1_pc_q;
        e1_inst_d = e1_inst_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, do_pop})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        e0_pc_d   = e1_pc_q;
                        e0_inst_d = e1_inst_q;
                        e1_pc_d   = push_pc;
                        e1_inst_d = push_inst;
                    end else begin
                        e0_pc_d   = push_pc;
                        e0_inst_d = push_inst;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_pc_d   = push_pc;
                        e0_inst_d = push_inst;
                        count_d   = 2'd1;
                    end else if (count_q == 2'd1) begin
                        e1_pc_d   = push_pc;
                        e1_inst_d = push_inst;
                        count_d   = 2'd2;
                    end
                end
                2'b01: begin
                    e0_pc_d   = e1_pc_q;
                    e0_inst_d = e1_inst_q;
                    count_d   = count_q - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            e0_pc_q   <= '0;
            e0_inst_q <= '0;
            e1_pc_q   <= '0;
            e1_inst_q <= '0;
        end else begin
            count_q   <= count_d;
            e0_pc_q   <= e0_pc_d;
            e0_inst_q <= e0_inst_d;
            e1_pc_q   <= e1_pc_d;
            e1_inst_q <= e1_inst_d;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch front end: owns the PC, issues req/ack word fetches,
// buffers returned words and presents {pc, inst} on a valid/ready port.
module if_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam addr_t STEP = addr_t'(PC_STEP);

    fetch_state_t state_q, state_d;
    addr_t        pc_q, pc_d;
    addr_t        addr_q, addr_d;
    logic         req_q, req_d;
    logic         push, pop;
    logic [1:0]   buf_count, occ_post_pop;
    addr_t        pc_next, redirect_word;

    assign pop           = out_valid & out_ready;
    assign out_valid     = (buf_count != 2'd0);
    assign occ_post_pop  = buf_count - {1'b0, pop};
    assign pc_next       = pc_q + STEP;
    assign redirect_word = redirect_pc & ~32'h3;
    assign imem_req      = req_q;
    assign imem_addr     = addr_q;

    // Fetch FSM. A back-to-back launch is only allowed when the buffer will
    // still have room after this completion's push, so it can never overflow.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_word;
                end else if (en && (occ_post_pop < 2'd2)) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_word;
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_next;
                    if (en && (occ_post_pop == 2'd0)) begin
                        addr_d = pc_next;
                    end else begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_word;
                end
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, PC and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    if_fetch_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_pc   (addr_q),
        .push_inst (imem_rdata),
        .head_pc   (out_pc),
        .head_inst (out_inst),
        .count     (buf_count)
    );

endmodule
